// File: rtl/amo_exec_unit_if.sv
// amo_exec_unit_if: request/response handshake and data-memory port of the atomic execution unit
interface amo_exec_unit_if #(
   parameter int XLEN   = 64,
   parameter int ADDR_W = 32
);
   logic              req_valid_i;
   logic              req_ready_o;
   logic [3:0]        amoop_i;
   logic              dword_i;
   logic [ADDR_W-1:0] addr_i;
   logic [XLEN-1:0]   rs2_i;
   logic              rsp_valid_o;
   logic [XLEN-1:0]   rd_o;
   logic              err_o;
   logic              mem_req_o;
   logic              mem_we_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic              mem_dword_o;
   logic [XLEN-1:0]   mem_wdata_o;
   logic              mem_gnt_i;
   logic              mem_rvalid_i;
   logic [XLEN-1:0]   mem_rdata_i;
   modport slave (
      input  req_valid_i, amoop_i, dword_i, addr_i, rs2_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
      output req_ready_o, rsp_valid_o, rd_o, err_o, mem_req_o, mem_we_o, mem_addr_o, mem_dword_o, mem_wdata_o
   );
   modport master (
      output req_valid_i, amoop_i, dword_i, addr_i, rs2_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
      input  req_ready_o, rsp_valid_o, rd_o, err_o, mem_req_o, mem_we_o, mem_addr_o, mem_dword_o, mem_wdata_o
   );
endinterface

// File: rtl/amo_exec_unit.sv
// amo_exec_unit: RV32A/RV64A AMO, LR and SC executed as read-modify-write sequences on the data-memory port
module amo_exec_unit #(
   parameter int XLEN     = 64,
   parameter int ADDR_W   = 32,
   parameter int RSV_GRAN = 3
) (
   input logic            clk,
   input logic            arst_n,
   amo_exec_unit_if.slave bus
);
   localparam logic [3:0] OP_ADD = 4'd0, OP_SWAP = 4'd1, OP_XOR = 4'd2, OP_AND = 4'd3, OP_OR = 4'd4,
                          OP_MIN = 4'd5, OP_MAX = 4'd6, OP_MINU = 4'd7, OP_MAXU = 4'd8, OP_LR = 4'd9, OP_SC = 4'd10;
   typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, RESP} state_t;
   state_t                     state, state_nx;
   logic [3:0]                 op_q;
   logic                       dw_q, err_q, sc_fail_q, rsv_valid;
   logic [ADDR_W-1:0]          addr_q;
   logic [XLEN-1:0]            rs2_q, old_q, op_b, amo_res;
   logic [ADDR_W-RSV_GRAN-1:0] rsv_tag;
   logic                       req_err, is_sc, is_lr, rsv_hit, wr_skip;

   assign req_err = bus.amoop_i > OP_SC || (bus.dword_i && XLEN == 32) || (|bus.addr_i[1:0]) || (bus.dword_i && bus.addr_i[2]);
   assign is_sc   = op_q == OP_SC;
   assign is_lr   = op_q == OP_LR;
   assign rsv_hit = rsv_valid && rsv_tag == addr_q[ADDR_W-1:RSV_GRAN];
   // a failing SC never touches memory and falls straight through to the response
   assign wr_skip = is_sc && !rsv_hit;
   // word ops run on sign-extended operands so one XLEN-wide ALU gives correct low-32-bit results
   assign op_b    = dw_q ? rs2_q : XLEN'($signed(rs2_q[31:0]));

   // read-modify-write result for the AMO write phase
   always_comb begin
      amo_res = op_b;
      case (op_q)
         OP_ADD:  amo_res = old_q + op_b;
         OP_SWAP: amo_res = op_b;
         OP_XOR:  amo_res = old_q ^ op_b;
         OP_AND:  amo_res = old_q & op_b;
         OP_OR:   amo_res = old_q | op_b;
         OP_MIN:  amo_res = $signed(old_q) < $signed(op_b) ? old_q : op_b;
         OP_MAX:  amo_res = $signed(old_q) > $signed(op_b) ? old_q : op_b;
         OP_MINU: amo_res = old_q < op_b ? old_q : op_b;
         OP_MAXU: amo_res = old_q > op_b ? old_q : op_b;
         default: amo_res = op_b;
      endcase
   end

   // sequencing state register
   always_ff @(posedge clk or negedge arst_n)
      if (!arst_n) state <= IDLE;
      else state <= state_nx;

   // next-state logic; a grant seen while requesting completes that access
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (bus.req_valid_i) state_nx = req_err ? RESP : (bus.amoop_i == OP_SC ? WR_REQ : RD_REQ);
         RD_REQ:  if (bus.mem_gnt_i) state_nx = RD_WAIT;
         RD_WAIT: if (bus.mem_rvalid_i) state_nx = is_lr ? RESP : WR_REQ;
         WR_REQ:  if (wr_skip || bus.mem_gnt_i) state_nx = RESP;
         RESP:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // request latch, loaded old value and SC outcome
   always_ff @(posedge clk or negedge arst_n)
      if (!arst_n) begin
         op_q      <= '0;
         dw_q      <= 1'b0;
         addr_q    <= '0;
         rs2_q     <= '0;
         err_q     <= 1'b0;
         old_q     <= '0;
         sc_fail_q <= 1'b0;
      end else begin
         if (state == IDLE && bus.req_valid_i) begin
            op_q   <= bus.amoop_i;
            dw_q   <= bus.dword_i;
            addr_q <= bus.addr_i;
            rs2_q  <= bus.rs2_i;
            err_q  <= req_err;
         end
         if (state == RD_WAIT && bus.mem_rvalid_i) old_q <= dw_q ? bus.mem_rdata_i : XLEN'($signed(bus.mem_rdata_i[31:0]));
         if (state == WR_REQ) sc_fail_q <= wr_skip;
      end

   // reservation: set by LR, dropped by any SC leaving WR_REQ or an AMO write granted to the same granule
   always_ff @(posedge clk or negedge arst_n)
      if (!arst_n) begin
         rsv_valid <= 1'b0;
         rsv_tag   <= '0;
      end else if (state == RD_WAIT && bus.mem_rvalid_i && is_lr) begin
         rsv_valid <= 1'b1;
         rsv_tag   <= addr_q[ADDR_W-1:RSV_GRAN];
      end else if (state == WR_REQ && state_nx == RESP && (is_sc || rsv_hit)) begin
         rsv_valid <= 1'b0;
      end

   assign bus.req_ready_o = state == IDLE;
   assign bus.rsp_valid_o = state == RESP;
   assign bus.err_o       = state == RESP && err_q;
   assign bus.rd_o        = (state != RESP || err_q) ? '0 : is_sc ? XLEN'(sc_fail_q) : old_q;
   assign bus.mem_req_o   = state == RD_REQ || (state == WR_REQ && !wr_skip);
   assign bus.mem_we_o    = state == WR_REQ && !wr_skip;
   assign bus.mem_addr_o  = addr_q & {{(ADDR_W-3){1'b1}}, ~dw_q, 2'b00};
   assign bus.mem_dword_o = dw_q;
   assign bus.mem_wdata_o = dw_q ? amo_res : XLEN'(amo_res[31:0]);
endmodule

// File: tb/tb_amo_exec_unit.sv
// tb_amo_exec_unit: directed checks of the atomic execution unit against a byte-array memory model
module tb_amo_exec_unit;
   localparam logic [3:0] OP_ADD = 4'd0, OP_SWAP = 4'd1, OP_XOR = 4'd2, OP_AND = 4'd3, OP_OR = 4'd4,
                          OP_MIN = 4'd5, OP_MAX = 4'd6, OP_MINU = 4'd7, OP_MAXU = 4'd8, OP_LR = 4'd9, OP_SC = 4'd10;
   typedef struct packed {
      logic [3:0]  op;
      logic        dw;
      logic [11:0] a;
      logic [63:0] init;
      logic [63:0] r2;
      logic [63:0] exp_rd;
      logic [63:0] exp_mem;
   } amo_vec_t;
   typedef struct packed {
      logic [3:0]  op;
      logic        dw;
      logic [11:0] a;
   } err_vec_t;

   logic        clk = 1'b0;
   logic        arst_n;
   int          n_chk = 0, n_fail = 0;
   logic [7:0]  mem [0:4095];
   logic        rv_q = 1'b0, rv_en = 1'b1, stray = 1'b0;
   logic [63:0] rdat_q = '0;
   int          gnt_lat = 0, wait_cnt = 0, gnt_cnt = 0, req_cyc = 0;
   logic        pk_en = 1'b0, pk_dw = 1'b0;
   logic [11:0] pk_a = '0;
   logic [63:0] pk_d = '0;

   amo_exec_unit_if #(.XLEN(64), .ADDR_W(32)) bus ();
   amo_exec_unit #(.XLEN(64), .ADDR_W(32), .RSV_GRAN(3)) dut (.clk(clk), .arst_n(arst_n), .bus(bus));

   always #5 clk = ~clk;
   assign bus.mem_gnt_i    = bus.mem_req_o && wait_cnt >= gnt_lat;
   assign bus.mem_rvalid_i = rv_q || stray;
   assign bus.mem_rdata_i  = rdat_q;

   function automatic logic [63:0] mem_rd(input logic [11:0] a, input logic dw);
      logic [63:0] v = '0;
      for (int i = 0; i < 8; i++) if (i < 4 || dw) v[8*i +: 8] = mem[12'(a + i)];
      return v;
   endfunction

   // memory model: optional grant delay, read data one cycle after the read grant, word reads carry junk upper bits
   always @(posedge clk) begin
      rv_q <= 1'b0;
      req_cyc <= req_cyc + (bus.mem_req_o ? 1 : 0);
      wait_cnt <= (bus.mem_req_o && !bus.mem_gnt_i) ? wait_cnt + 1 : 0;
      if (pk_en) begin
         for (int i = 0; i < 8; i++) if (i < 4 || pk_dw) mem[12'(pk_a + i)] <= pk_d[8*i +: 8];
      end
      if (bus.mem_req_o && bus.mem_gnt_i) begin
         gnt_cnt <= gnt_cnt + 1;
         if (bus.mem_we_o) begin
            for (int i = 0; i < 8; i++) if (i < 4 || bus.mem_dword_o) mem[12'(bus.mem_addr_o[11:0] + i)] <= bus.mem_wdata_o[8*i +: 8];
         end else begin
            rv_q   <= rv_en;
            rdat_q <= mem_rd(bus.mem_addr_o[11:0], bus.mem_dword_o) | (bus.mem_dword_o ? 64'h0 : 64'hA5A5A5A5_00000000);
         end
      end
   end

   task automatic poke(input logic [11:0] a, input logic dw, input logic [63:0] d);
      pk_en = 1'b1; pk_a = a; pk_dw = dw; pk_d = d;
      @(posedge clk); #1;
      pk_en = 1'b0;
   endtask

   task automatic do_req(input logic [3:0] op, input logic dw, input logic [11:0] a, input logic [63:0] r2,
                         output logic [63:0] rd, output logic er, output int lat, output int ng, output int nr);
      int n = 0, g0, r0;
      while (!bus.req_ready_o && n < 20) begin @(posedge clk); #1; n++; end
      g0 = gnt_cnt; r0 = req_cyc;
      bus.req_valid_i = 1'b1; bus.amoop_i = op; bus.dword_i = dw; bus.addr_i = {20'h0, a}; bus.rs2_i = r2;
      @(posedge clk); #1;
      bus.req_valid_i = 1'b0;
      lat = 1; rd = 'x; er = 1'bx;
      while (!bus.rsp_valid_o && lat < 40) begin @(posedge clk); #1; lat++; end
      if (bus.rsp_valid_o) begin rd = bus.rd_o; er = bus.err_o; end
      ng = gnt_cnt - g0; nr = req_cyc - r0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      #1;
      n_chk++; if (bus.req_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset req_ready: got %b expected 1", bus.req_ready_o); end
      n_chk++; if (bus.rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset rsp_valid: got %b expected 0", bus.rsp_valid_o); end
      n_chk++; if (bus.mem_req_o !== 1'b0) begin n_fail++; $display("FAIL reset mem_req: got %b expected 0", bus.mem_req_o); end
      n_chk++; if (bus.mem_we_o !== 1'b0) begin n_fail++; $display("FAIL reset mem_we: got %b expected 0", bus.mem_we_o); end
      n_chk++; if (bus.rd_o !== 64'h0) begin n_fail++; $display("FAIL reset rd: got %h expected 0", bus.rd_o); end
      n_chk++; if (bus.err_o !== 1'b0) begin n_fail++; $display("FAIL reset err: got %b expected 0", bus.err_o); end
      arst_n = 1'b1;
      @(posedge clk); #1;
      n_chk++; if (bus.req_ready_o !== 1'b1) begin n_fail++; $display("FAIL post-reset req_ready: got %b expected 1", bus.req_ready_o); end
   endtask

   task automatic test_amo_ops();
      amo_vec_t tv [12];
      logic [63:0] rd;
      logic er;
      int lat, ng, nr;
      tv[0]  = '{OP_ADD,  1'b0, 12'h100, 64'h7FFFFFFF, 64'd1, 64'h7FFFFFFF, 64'h80000000};
      tv[1]  = '{OP_MIN,  1'b1, 12'h108, 64'hFFFFFFFF_FFFFFFFE, 64'd5, 64'hFFFFFFFF_FFFFFFFE, 64'hFFFFFFFF_FFFFFFFE};
      tv[2]  = '{OP_MINU, 1'b1, 12'h108, 64'hFFFFFFFF_FFFFFFFE, 64'd5, 64'hFFFFFFFF_FFFFFFFE, 64'd5};
      tv[3]  = '{OP_MAX,  1'b0, 12'h110, 64'hFFFFFFFF, 64'd0, 64'hFFFFFFFF_FFFFFFFF, 64'h0};
      tv[4]  = '{OP_MAXU, 1'b0, 12'h114, 64'h80000000, 64'd1, 64'hFFFFFFFF_80000000, 64'h80000000};
      tv[5]  = '{OP_XOR,  1'b0, 12'h118, 64'h0F0F00FF, 64'h00FF00FF, 64'h0F0F00FF, 64'h0FF00000};
      tv[6]  = '{OP_AND,  1'b1, 12'h120, 64'hFF00FF00_FF00FF00, 64'h0F0F0F0F_0F0F0F0F, 64'hFF00FF00_FF00FF00, 64'h0F000F00_0F000F00};
      tv[7]  = '{OP_OR,   1'b0, 12'h128, 64'h00000001, 64'h12345678_80000000, 64'h1, 64'h80000001};
      tv[8]  = '{OP_SWAP, 1'b1, 12'h130, 64'h11223344_55667788, 64'hCAFEBABE_DEADBEEF, 64'h11223344_55667788, 64'hCAFEBABE_DEADBEEF};
      tv[9]  = '{OP_MIN,  1'b0, 12'h138, 64'h3, 64'hFFFFFFFF, 64'h3, 64'hFFFFFFFF};
      tv[10] = '{OP_ADD,  1'b1, 12'h140, 64'hFFFFFFFF_FFFFFFFF, 64'd2, 64'hFFFFFFFF_FFFFFFFF, 64'h1};
      tv[11] = '{OP_MAX,  1'b1, 12'h148, 64'h80000000_00000000, 64'd1, 64'h80000000_00000000, 64'h1};
      for (int i = 0; i < 12; i++) begin
         poke(tv[i].a, tv[i].dw, tv[i].init);
         do_req(tv[i].op, tv[i].dw, tv[i].a, tv[i].r2, rd, er, lat, ng, nr);
         n_chk++; if (rd !== tv[i].exp_rd) begin n_fail++; $display("FAIL amo[%0d] rd: got %h expected %h", i, rd, tv[i].exp_rd); end
         n_chk++; if (er !== 1'b0) begin n_fail++; $display("FAIL amo[%0d] err: got %b expected 0", i, er); end
         n_chk++; if (mem_rd(tv[i].a, tv[i].dw) !== tv[i].exp_mem) begin n_fail++; $display("FAIL amo[%0d] mem: got %h expected %h", i, mem_rd(tv[i].a, tv[i].dw), tv[i].exp_mem); end
         n_chk++; if (lat !== 4) begin n_fail++; $display("FAIL amo[%0d] latency: got %0d expected 4", i, lat); end
      end
   endtask

   task automatic test_lr_sc();
      logic [63:0] rd;
      logic er;
      int lat, ng, nr;
      poke(12'h200, 1'b0, 64'h80000010);
      poke(12'h204, 1'b0, 64'h0);
      do_req(OP_LR, 1'b0, 12'h200, 64'h0, rd, er, lat, ng, nr);
      n_chk++; if (rd !== 64'hFFFFFFFF_80000010) begin n_fail++; $display("FAIL lr_w rd: got %h expected ffffffff80000010", rd); end
      n_chk++; if (lat !== 3) begin n_fail++; $display("FAIL lr_w latency: got %0d expected 3", lat); end
      do_req(OP_SC, 1'b0, 12'h204, 64'd9, rd, er, lat, ng, nr);
      n_chk++; if (rd !== 64'h0) begin n_fail++; $display("FAIL sc_w pass rd: got %h expected 0", rd); end
      n_chk++; if (mem_rd(12'h204, 1'b0) !== 64'd9) begin n_fail++; $display("FAIL sc_w pass mem: got %h expected 9", mem_rd(12'h204, 1'b0)); end
      n_chk++; if (lat !== 2) begin n_fail++; $display("FAIL sc_w pass latency: got %0d expected 2", lat); end
      n_chk++; if (nr !== 1) begin n_fail++; $display("FAIL sc_w pass request cycles: got %0d expected 1", nr); end
      n_chk++; if (bus.req_ready_o !== 1'b1 || bus.rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL after rsp ready/valid: got %b/%b expected 1/0", bus.req_ready_o, bus.rsp_valid_o); end
      do_req(OP_SC, 1'b0, 12'h204, 64'd7, rd, er, lat, ng, nr);
      n_chk++; if (rd !== 64'h1) begin n_fail++; $display("FAIL sc_w again rd: got %h expected 1", rd); end
      n_chk++; if (nr !== 0) begin n_fail++; $display("FAIL sc_w again request cycles: got %0d expected 0", nr); end
      n_chk++; if (mem_rd(12'h204, 1'b0) !== 64'd9) begin n_fail++; $display("FAIL sc_w again mem: got %h expected 9", mem_rd(12'h204, 1'b0)); end
      n_chk++; if (lat !== 2) begin n_fail++; $display("FAIL sc_w again latency: got %0d expected 2", lat); end
      poke(12'h300, 1'b1, 64'h0);
      do_req(OP_LR, 1'b0, 12'h200, 64'h0, rd, er, lat, ng, nr);
      do_req(OP_LR, 1'b1, 12'h300, 64'h0, rd, er, lat, ng, nr);
      do_req(OP_SC, 1'b0, 12'h200, 64'h77, rd, er, lat, ng, nr);
      n_chk++; if (rd !== 64'h1) begin n_fail++; $display("FAIL lr overwrite sc rd: got %h expected 1", rd); end
      n_chk++; if (mem_rd(12'h200, 1'b0) !== 64'h80000010) begin n_fail++; $display("FAIL lr overwrite mem: got %h expected 80000010", mem_rd(12'h200, 1'b0)); end
   endtask

   task automatic test_reservation_kill();
      logic [63:0] rd;
      logic er;
      int lat, ng, nr;
      poke(12'h300, 1'b1, 64'h01234567_89ABCDEF);
      do_req(OP_LR, 1'b1, 12'h300, 64'h0, rd, er, lat, ng, nr);
      n_chk++; if (rd !== 64'h01234567_89ABCDEF) begin n_fail++; $display("FAIL lr_d rd: got %h expected 0123456789abcdef", rd); end
      do_req(OP_SWAP, 1'b1, 12'h300, 64'h55, rd, er, lat, ng, nr);
      n_chk++; if (rd !== 64'h01234567_89ABCDEF) begin n_fail++; $display("FAIL swap_d rd: got %h expected 0123456789abcdef", rd); end
      do_req(OP_SC, 1'b1, 12'h300, 64'h99, rd, er, lat, ng, nr);
      n_chk++; if (rd !== 64'h1) begin n_fail++; $display("FAIL sc_d after amo rd: got %h expected 1", rd); end
      n_chk++; if (nr !== 0) begin n_fail++; $display("FAIL sc_d after amo request cycles: got %0d expected 0", nr); end
      n_chk++; if (mem_rd(12'h300, 1'b1) !== 64'h55) begin n_fail++; $display("FAIL sc_d after amo mem: got %h expected 55", mem_rd(12'h300, 1'b1)); end
      poke(12'h304, 1'b0, 64'h0);
      do_req(OP_LR, 1'b1, 12'h300, 64'h0, rd, er, lat, ng, nr);
      do_req(OP_ADD, 1'b0, 12'h304, 64'h1, rd, er, lat, ng, nr);
      do_req(OP_SC, 1'b1, 12'h300, 64'h66, rd, er, lat, ng, nr);
      n_chk++; if (rd !== 64'h1) begin n_fail++; $display("FAIL sc_d same granule amo rd: got %h expected 1", rd); end
      do_req(OP_LR, 1'b1, 12'h300, 64'h0, rd, er, lat, ng, nr);
      do_req(OP_ADD, 1'b0, 12'h400, 64'h1, rd, er, lat, ng, nr);
      do_req(OP_SC, 1'b1, 12'h300, 64'hAB, rd, er, lat, ng, nr);
      n_chk++; if (rd !== 64'h0) begin n_fail++; $display("FAIL sc_d other granule amo rd: got %h expected 0", rd); end
      n_chk++; if (mem_rd(12'h300, 1'b1) !== 64'hAB) begin n_fail++; $display("FAIL sc_d other granule mem: got %h expected ab", mem_rd(12'h300, 1'b1)); end
   endtask

   task automatic test_errors();
      err_vec_t ev [7];
      logic [63:0] rd;
      logic er;
      int lat, ng, nr;
      ev[0] = '{OP_OR, 1'b0, 12'h102};
      ev[1] = '{OP_ADD, 1'b1, 12'h104};
      ev[2] = '{OP_ADD, 1'b0, 12'h101};
      ev[3] = '{4'd11, 1'b0, 12'h100};
      ev[4] = '{4'd15, 1'b1, 12'h108};
      ev[5] = '{OP_LR, 1'b1, 12'h10C};
      ev[6] = '{OP_SC, 1'b0, 12'h206};
      for (int i = 0; i < 7; i++) begin
         do_req(ev[i].op, ev[i].dw, ev[i].a, 64'h1234, rd, er, lat, ng, nr);
         n_chk++; if (er !== 1'b1) begin n_fail++; $display("FAIL err[%0d] err: got %b expected 1", i, er); end
         n_chk++; if (rd !== 64'h0) begin n_fail++; $display("FAIL err[%0d] rd: got %h expected 0", i, rd); end
         n_chk++; if (nr !== 0) begin n_fail++; $display("FAIL err[%0d] request cycles: got %0d expected 0", i, nr); end
         n_chk++; if (lat !== 1) begin n_fail++; $display("FAIL err[%0d] latency: got %0d expected 1", i, lat); end
      end
   endtask

   task automatic test_gnt_stall();
      logic [63:0] rd;
      logic er;
      int lat, ng, nr;
      poke(12'h500, 1'b1, 64'd10);
      gnt_lat = 2;
      do_req(OP_ADD, 1'b1, 12'h500, 64'd5, rd, er, lat, ng, nr);
      gnt_lat = 0;
      n_chk++; if (rd !== 64'd10) begin n_fail++; $display("FAIL stall rd: got %h expected a", rd); end
      n_chk++; if (mem_rd(12'h500, 1'b1) !== 64'd15) begin n_fail++; $display("FAIL stall mem: got %h expected f", mem_rd(12'h500, 1'b1)); end
      n_chk++; if (ng !== 2) begin n_fail++; $display("FAIL stall grants: got %0d expected 2", ng); end
      n_chk++; if (nr !== 6) begin n_fail++; $display("FAIL stall request cycles: got %0d expected 6", nr); end
      n_chk++; if (lat !== 8) begin n_fail++; $display("FAIL stall latency: got %0d expected 8", lat); end
   endtask

   task automatic test_reset_mid_op();
      logic [63:0] rd;
      logic er;
      int lat, ng, nr;
      poke(12'h700, 1'b0, 64'h0);
      poke(12'h600, 1'b0, 64'd5);
      do_req(OP_LR, 1'b0, 12'h700, 64'h0, rd, er, lat, ng, nr);
      rv_en = 1'b0;
      bus.req_valid_i = 1'b1; bus.amoop_i = OP_ADD; bus.dword_i = 1'b0; bus.addr_i = 32'h600; bus.rs2_i = 64'd1;
      @(posedge clk); #1;
      bus.req_valid_i = 1'b0;
      n_chk++; if (bus.req_ready_o !== 1'b0) begin n_fail++; $display("FAIL busy req_ready: got %b expected 0", bus.req_ready_o); end
      @(posedge clk); #1;
      arst_n = 1'b0;
      #1;
      n_chk++; if (bus.mem_req_o !== 1'b0) begin n_fail++; $display("FAIL mid reset mem_req: got %b expected 0", bus.mem_req_o); end
      @(posedge clk); #1;
      n_chk++; if (bus.req_ready_o !== 1'b1) begin n_fail++; $display("FAIL mid reset req_ready: got %b expected 1", bus.req_ready_o); end
      arst_n = 1'b1;
      rv_en = 1'b1;
      stray = 1'b1;
      @(posedge clk); #1;
      stray = 1'b0;
      n_chk++; if (bus.rsp_valid_o !== 1'b0 || bus.req_ready_o !== 1'b1) begin n_fail++; $display("FAIL stray rvalid rsp/ready: got %b/%b expected 0/1", bus.rsp_valid_o, bus.req_ready_o); end
      n_chk++; if (mem_rd(12'h600, 1'b0) !== 64'd5) begin n_fail++; $display("FAIL mid reset mem: got %h expected 5", mem_rd(12'h600, 1'b0)); end
      do_req(OP_SC, 1'b0, 12'h700, 64'h3, rd, er, lat, ng, nr);
      n_chk++; if (rd !== 64'h1) begin n_fail++; $display("FAIL sc after reset rd: got %h expected 1", rd); end
      do_req(OP_ADD, 1'b0, 12'h600, 64'd1, rd, er, lat, ng, nr);
      n_chk++; if (rd !== 64'd5) begin n_fail++; $display("FAIL add after reset rd: got %h expected 5", rd); end
      n_chk++; if (mem_rd(12'h600, 1'b0) !== 64'd6) begin n_fail++; $display("FAIL add after reset mem: got %h expected 6", mem_rd(12'h600, 1'b0)); end
   endtask

   initial begin
      arst_n = 1'b0;
      bus.req_valid_i = 1'b0; bus.amoop_i = '0; bus.dword_i = 1'b0; bus.addr_i = '0; bus.rs2_i = '0;
      repeat (2) @(posedge clk);
      test_reset();
      test_amo_ops();
      test_lr_sc();
      test_reservation_kill();
      test_errors();
      test_gnt_stall();
      test_reset_mid_op();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
